step_down_timer: RTL
====================

Name: step_down_timer

Overview:
Parametrised programmable down-counter/timer for the datapath.
- Generalises the team's single-bit enable flip-flop, fixed subtractor, equality checker and 2:1 mux into one block.
- Features: loadable start value, programmable decrement step, saturation at zero, one-shot or periodic auto-reload, compare-match flag, terminal-count pulse.
- Used by control FSMs for wait-states, bit timers and periodic tick generation.

Parameters:
WIDTH, 8, counter, load value and compare value width in bits
STEP_W, 4, decrement-step width in bits (STEP_W <= WIDTH)

Ports:
Clk  input  1  clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Load  input  1  load LoadVal into counter and reload register
LoadVal  input  WIDTH  value captured on Load
Start  input  1  begin counting (IDLE only)
Stop  input  1  halt counting, hold Count
En  input  1  tick enable; one decrement per cycle with En=1 in RUN
Step  input  STEP_W  decrement amount per tick, zero-extended to WIDTH
Periodic  input  1  1 = auto-reload on terminal count; 0 = one-shot
CmpVal  input  WIDTH  compare value for Match
Count  output  WIDTH  current counter value (registered)
Busy  output  1  1 while in RUN
Match  output  1  registered; 1 when Count == CmpVal
Done  output  1  one-cycle terminal-count pulse

Behaviour:
- Reset is asynchronous, active-high, clock Clk. During and after reset: Count=0, reload register=0, state=IDLE, Busy=0, Match=0, Done=0.
- Priority, highest first: Reset > Load > Stop > Start > En tick.
- States: IDLE, RUN. Busy=1 exactly when state==RUN (registered).
- Load, any state: next cycle Count=LoadVal, reload reg=LoadVal, state=IDLE, Done=0. Load during RUN aborts the run.
- Start in IDLE (no Load/Stop):
  - Count!=0 -> RUN next cycle; Count unchanged in that cycle.
  - Count==0 -> stay IDLE; Done=1 for one cycle.
- Start in RUN is ignored.
- Stop in RUN -> IDLE next cycle; Count holds. Stop+Start in the same cycle -> Stop wins.
- RUN with En=0: hold everything; Done=0.
- RUN with En=1, s = zero-extended Step:
  - s==0 -> Count holds; no terminal event.
  - Count > s -> Count = Count - s; no terminal event.
  - Count <= s -> terminal event; never wraps below zero (saturating).
    - Periodic=0: Count=0, state=IDLE, Done=1 in the same cycle Count shows 0.
    - Periodic=1: Count=reload reg, stay RUN, Done=1 for that cycle.
    - Periodic=1 with reload reg==0: Count stays 0 and Done pulses on every En tick.
- Done is high for one cycle per terminal event, otherwise 0. Consecutive terminal events give Done high in consecutive cycles.
- Match is a register updated every cycle with (Count_next == CmpVal), so it aligns with Count. A CmpVal change is reflected one cycle later. Match is 0 out of reset even if CmpVal==0.
- Periodic is sampled at the terminal event only; changing it mid-run is legal.
- Latency: Load/Start/Stop/tick take effect on the Count/Busy/Done outputs at the next rising edge.
- Arithmetic: compare and subtract are unsigned, WIDTH bits; no carry or borrow output.
- Reset asserted mid-run returns all outputs to reset values immediately.

Decomposition:
- Shared package: state typedef enum {IDLE, RUN}.
- One sub-module, sat_step_sub (parameter WIDTH): inputs a, b; outputs diff = a-b and term = (a <= b) && (b != 0). Purely combinational, generalising the team subtractor with a terminal flag.
- The equality compare stays inline.

Test Plan:
- Reset, then Load LoadVal=10, Step=3, Periodic=0, Start, En=1 continuous -> Count 10,7,4,1,0. Done=1 only in the cycle Count=0; Busy falls with it.
- Same as above with Periodic=1 -> Count 10,7,4,1,10,7,... Done pulses each time Count reloads to 10; Busy stays 1.
- LoadVal=6, CmpVal=4, Step=2, Start, En=1 -> Match=1 exactly in the cycle Count=4, 0 otherwise.
- RUN with Count=9, Stop and Start asserted together -> state IDLE, Count holds 9. Then Start alone with En=0 for 3 cycles -> Count holds 9, Busy=1.
- Step=0 in RUN with En=1 -> Count holds, no Done. Start in IDLE with Count=0 -> Done=1 for one cycle, Busy stays 0.
- Assert Reset mid-run at Count=5 -> all outputs 0 immediately. Load asserted in RUN with LoadVal=20 -> Count=20, state IDLE, Done=0.

Source files
------------

// File: rtl/step_down_timer_pkg.sv
// Shared types for the step-down timer.
// There are two states. IDLE holds Count. RUN applies a decrement on each enabled tick.
package step_down_timer_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/step_down_timer_if.sv
// Control/status bundle for step_down_timer.
// Status outputs are registered and reflect control inputs one edge later; there is no backpressure.
interface step_down_timer_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              Load;
  logic [WIDTH-1:0]  LoadVal;
  logic              Start;
  logic              Stop;
  logic              En;
  logic [STEP_W-1:0] Step;
  logic              Periodic;
  logic [WIDTH-1:0]  CmpVal;
  logic [WIDTH-1:0]  Count;
  logic              Busy;
  logic              Match;
  logic              Done;

  modport master (
    output Load, LoadVal, Start, Stop, En, Step, Periodic, CmpVal,
    input  Count, Busy, Match, Done
  );

  modport slave (
    input  Load, LoadVal, Start, Stop, En, Step, Periodic, CmpVal,
    output Count, Busy, Match, Done
  );
endinterface

// File: rtl/step_down_timer_sat_step_sub.sv
// Unsigned subtractor with a terminal flag. The flag is set when a nonzero step reaches or passes zero.
// The block is purely combinational, with zero latency and no backpressure.
module sat_step_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             term
);
  assign diff = a - b;
  assign term = (a <= b) && (b != '0);
endmodule

// File: rtl/step_down_timer.sv
// Programmable down-counter with saturating step, optional auto-reload, compare match and terminal pulse.
// Every input takes effect at the next rising Clk edge; the block never stalls its driver.
module step_down_timer
  import step_down_timer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  step_down_timer_if.slave bus
);
  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic [WIDTH-1:0] step_ext, diff;
  logic             term, done, done_n, match;

  assign step_ext = WIDTH'(bus.Step);

  sat_step_sub #(.WIDTH(WIDTH)) u_sub (
    .a    (count),
    .b    (step_ext),
    .diff (diff),
    .term (term)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
      match  <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      done   <= done_n;
      match  <= (count_n == bus.CmpVal);
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    done_n   = 1'b0;
    if (bus.Load) begin
      count_n  = bus.LoadVal;
      reload_n = bus.LoadVal;
      state_n  = IDLE;
    end else if (state == RUN) begin
      if (bus.Stop) begin
        state_n = IDLE;
      end else if (bus.En) begin
        // A zero step yields diff == count, so that case holds Count without a separate branch.
        if (term) begin
          done_n = 1'b1;
          if (bus.Periodic) begin
            count_n = reload;
          end else begin
            count_n = '0;
            state_n = IDLE;
          end
        end else begin
          count_n = diff;
        end
      end
    end else if (bus.Start && !bus.Stop) begin
      if (count != '0) state_n = RUN;
      else             done_n  = 1'b1;
    end
  end

  assign bus.Count = count;
  assign bus.Busy  = (state == RUN);
  assign bus.Match = match;
  assign bus.Done  = done;
endmodule
